swizzle_pipe: RTL and testbench
===============================

SWIZZLE_PIPE -- requirements
Module: swizzle_pipe

Interface
REQ-001 Parameter DATA_W, default 128: data width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter CNT_W, default 16: width of the transfer counter.
REQ-003 Port clock, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: input word is valid.
REQ-006 Port in_ready, output, 1: block can accept an input word.
REQ-007 Port in_data, input, DATA_W: input word.
REQ-008 Port in_mode, input, 2: swizzle mode, sampled together with in_data.
REQ-009 Port out_valid, output, 1: output word is valid.
REQ-010 Port out_ready, input, 1: consumer accepts the output word.
REQ-011 Port out_data, output, DATA_W: swizzled word.
REQ-012 Port xfer_cnt, output, CNT_W: count of completed output handshakes.
REQ-013 Port out_par, output, DATA_W/8: even parity per output byte; present only under SWIZZLE_PARITY_EN.

Function
REQ-014 Mode 0 SHALL pass the word through unchanged.
REQ-015 Mode 1 SHALL swap the two nibbles within every byte.
REQ-016 Mode 2 SHALL reverse byte order: byte i maps to byte DATA_W/8-1-i.
REQ-017 Mode 3 SHALL reverse bit order across the whole word: bit i maps to bit DATA_W-1-i.
REQ-018 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-019 The swizzle SHALL be applied before storage; out_valid SHALL rise on the cycle after the first input transfer (latency 1).
REQ-020 Storage SHALL be a 2-entry FIFO (skid buffer) with states EMPTY, ONE and FULL.
REQ-021 FIFO transitions:
- EMPTY -> ONE on input transfer.
- ONE -> FULL on input transfer without output transfer.
- ONE -> EMPTY on output transfer without input transfer.
- ONE stays ONE when both transfers occur in the same cycle.
- FULL -> ONE on output transfer.
REQ-022 in_ready SHALL equal (state != FULL) and SHALL be a registered output with no combinational path from out_ready.
REQ-023 In state FULL, in_valid SHALL be ignored and no input data SHALL be lost or overwritten.
REQ-024 Output order SHALL equal input order; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 Sustained throughput SHALL be one word per cycle when out_ready is held at 1.
REQ-026 xfer_cnt SHALL increment by 1 on each output transfer and SHALL wrap from all-ones to 0.

Reset
REQ-027 When reset=1 on a rising clock edge: state SHALL become EMPTY, out_valid=0, in_ready=1, xfer_cnt=0, out_data=0, and out_par=0 where present.
REQ-028 A reset asserted mid-operation SHALL discard all buffered words, and any handshake in that cycle SHALL have no effect.

Configuration
REQ-029 With macro SWIZZLE_PARITY_EN defined:
- out_par[j] SHALL equal the XOR of out_data byte j.
- out_par SHALL be stored alongside each FIFO entry so it stays aligned with out_data.
REQ-030 Without SWIZZLE_PARITY_EN, the out_par port and its storage SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Package swizzle_pkg SHALL hold:
- mode encodings MODE_PASS=0, MODE_NIBBLE=1, MODE_BYTEREV=2, MODE_BITREV=3;
- FIFO state encodings EMPTY, ONE, FULL.
REQ-032 Sub-module swizzle_core SHALL implement the purely combinational DATA_W-parametrised mode mux; swizzle_pipe SHALL hold all sequential logic.

Verification (DATA_W=128)
REQ-033 Mode 1, in_data=128'h1 -> out_data=128'h10 one cycle later; 128'h0 -> 128'h0.
REQ-034 Mode 2, 128'h1 -> 128'h0100_0000_0000_0000_0000_0000_0000_0000; mode 3, 128'h1 -> 128'h8000_0000_0000_0000_0000_0000_0000_0000; mode 0, 128'hA5 -> 128'hA5.
REQ-035 Hold out_ready=0 and drive 3 consecutive valid words -> first two accepted, in_ready=0 from the cycle after the second; release out_ready -> words emerge in order with no loss.
REQ-036 Stream 300 words with out_ready=1 at CNT_W=8 -> one word per cycle, xfer_cnt wraps to 44.
REQ-037 Assert reset while FULL -> next cycle out_valid=0, in_ready=1, xfer_cnt=0; the first post-reset word appears with latency 1.
REQ-038 With SWIZZLE_PARITY_EN, mode 0 in_data=128'h0301 -> out_par=16'h0001; under back-pressure out_par SHALL track each word.

Source files
------------

// File: rtl/swizzle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : swizzle_pkg
// Purpose  : Shared mode and FIFO-state encodings for the swizzle pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package swizzle_pkg;

  localparam logic [1:0] MODE_PASS    = 2'd0;
  localparam logic [1:0] MODE_NIBBLE  = 2'd1;
  localparam logic [1:0] MODE_BYTEREV = 2'd2;
  localparam logic [1:0] MODE_BITREV  = 2'd3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

endpackage : swizzle_pkg
`default_nettype wire

// File: rtl/swizzle_core.sv
`default_nettype none
// ============================================================================
// Module   : swizzle_core
// Purpose  : Combinational mode mux: pass, nibble swap, byte reverse, bit reverse.
// Revision : 1.0 - initial release
// ============================================================================
module swizzle_core
  import swizzle_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] out_data
);

  localparam int c_num_bytes = DATA_W / 8;

  logic [DATA_W-1:0] w_nibble;
  logic [DATA_W-1:0] w_byterev;
  logic [DATA_W-1:0] w_bitrev;

  for (genvar i = 0; i < c_num_bytes; i++) begin : g_byte
    assign w_nibble[8*i +: 8]  = {in_data[8*i +: 4], in_data[8*i+4 +: 4]};
    assign w_byterev[8*i +: 8] = in_data[8*(c_num_bytes-1-i) +: 8];
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    assign w_bitrev[i] = in_data[DATA_W-1-i];
  end

  always_comb begin
    out_data = in_data;
    unique case (mode)
      MODE_PASS:    out_data = in_data;
      MODE_NIBBLE:  out_data = w_nibble;
      MODE_BYTEREV: out_data = w_byterev;
      MODE_BITREV:  out_data = w_bitrev;
    endcase
  end

endmodule : swizzle_core
`default_nettype wire

// File: rtl/swizzle_pipe.sv
`default_nettype none
// ============================================================================
// Module   : swizzle_pipe
// Purpose  : Swizzle stage feeding a 2-entry skid FIFO with handshake counter.
//            Optional per-byte even parity output under SWIZZLE_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module swizzle_pipe
  import swizzle_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [1:0]          in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
`ifdef SWIZZLE_PARITY_EN
  output logic [DATA_W/8-1:0] out_par,
`endif
  output logic [CNT_W-1:0]    xfer_cnt
);

  localparam int c_num_bytes = DATA_W / 8;

  fifo_state_e       r_state;
  fifo_state_e       w_state_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [CNT_W-1:0]  r_xfer_cnt;
  logic [DATA_W-1:0] w_sw_data;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_skid;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_load_head;
  logic              w_load_skid;
  logic              w_head_from_skid;

  swizzle_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .in_data  (in_data),
    .mode     (in_mode),
    .out_data (w_sw_data)
  );

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  // r_head always presents the oldest word; r_skid catches the second one.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_head      = 1'b0;
    w_load_skid      = 1'b0;
    w_head_from_skid = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = ONE;
          w_load_head = 1'b1;
        end
      end
      ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_head = 1'b1;
        end else if (w_in_xfer) begin
          w_state_nxt = FULL;
          w_load_skid = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out_xfer) begin
          w_state_nxt      = ONE;
          w_head_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Ready/valid flags are registered from the next state so neither output
  // has a combinational path from the opposite handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_xfer_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
      if (w_out_xfer) begin
        r_xfer_cnt <= r_xfer_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_head) begin
        r_head <= w_sw_data;
      end else if (w_head_from_skid) begin
        r_head <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_sw_data;
      end
    end
  end

`ifdef SWIZZLE_PARITY_EN
  logic [c_num_bytes-1:0] w_sw_par;
  logic [c_num_bytes-1:0] r_head_par;
  logic [c_num_bytes-1:0] r_skid_par;

  for (genvar j = 0; j < c_num_bytes; j++) begin : g_par
    assign w_sw_par[j] = ^w_sw_data[8*j +: 8];
  end

  // Parity rides with its word through the same head/skid moves.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head_par <= '0;
      r_skid_par <= '0;
    end else begin
      if (w_load_head) begin
        r_head_par <= w_sw_par;
      end else if (w_head_from_skid) begin
        r_head_par <= r_skid_par;
      end
      if (w_load_skid) begin
        r_skid_par <= w_sw_par;
      end
    end
  end

  assign out_par = r_head_par;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_head;
  assign xfer_cnt  = r_xfer_cnt;

endmodule : swizzle_pipe
`default_nettype wire

// File: tb/tb_swizzle_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_swizzle_pipe
// Purpose  : Self-checking bench for swizzle_pipe against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_swizzle_pipe;

  localparam int DW = 128;
  localparam int CW = 8;
  localparam int NB = DW / 8;

  logic          clock     = 1'b0;
  logic          reset     = 1'b1;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [1:0]    in_mode   = 2'd0;
  logic [DW-1:0] in_data   = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] xfer_cnt;
`ifdef SWIZZLE_PARITY_EN
  logic [NB-1:0] out_par;
`endif

  swizzle_pipe #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef SWIZZLE_PARITY_EN
    .out_par   (out_par),
`endif
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clock = ~clock;

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [DW-1:0] q[$];
  logic [CW-1:0] m_cnt  = '0;
  bit            fresh  = 1'b1;
  bit            chk_en = 1'b0;

  function automatic logic [DW-1:0] ref_swz(input logic [1:0] m, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    logic [7:0]    b;
    r = d;
    case (m)
      2'd1: for (int i = 0; i < NB; i++) begin
              b = d[8*i +: 8];
              r[8*i +: 8] = 8'((b % 16) * 16 + (b / 16));
            end
      2'd2: r = {<<8{d}};
      2'd3: r = {<<{d}};
      default: r = d;
    endcase
    return r;
  endfunction

`ifdef SWIZZLE_PARITY_EN
  function automatic logic [NB-1:0] ref_par(input logic [DW-1:0] w);
    logic [NB-1:0] p;
    for (int j = 0; j < NB; j++) p[j] = ($countones(w[8*j +: 8]) % 2) == 1;
    return p;
  endfunction
`endif

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of at most two already-swizzled words.
  always @(posedge clock) begin : model
    bit do_out;
    bit do_in;
    if (reset) begin
      q.delete();
      m_cnt = '0;
      fresh = 1'b1;
    end else begin
      do_out = (q.size() > 0) && out_ready;
      do_in  = in_valid && (q.size() < 2);
      if (do_out) begin
        void'(q.pop_front());
        m_cnt++;
      end
      if (do_in) begin
        q.push_back(ref_swz(in_mode, in_data));
        fresh = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("in_ready", in_ready, q.size() < 2);
      check("out_valid", out_valid, q.size() > 0);
      check("xfer_cnt", xfer_cnt, m_cnt);
      if (q.size() > 0) begin
        check("out_data", out_data, q[0]);
`ifdef SWIZZLE_PARITY_EN
        check("out_par", out_par, ref_par(q[0]));
`endif
      end else if (fresh) begin
        check("out_data_rst", out_data, '0);
      end
    end
  end

  task automatic directed(input logic [1:0] m, input logic [DW-1:0] d,
                          input logic [DW-1:0] e, input string nm);
    @(negedge clock);
    in_valid = 1'b1; in_mode = m; in_data = d; out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check({nm, "_valid"}, out_valid, 1);
    check(nm, out_data, e);
    @(posedge clock); #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int stalls;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_xfer_cnt", xfer_cnt, 0);
    check("rst_out_data", out_data, 0);
    chk_en = 1'b1;
    reset  = 1'b0;

    directed(2'd1, 128'h1, 128'h10, "nibble_1");
    directed(2'd1, 128'h0, 128'h0, "nibble_0");
    directed(2'd2, 128'h1, 128'h0100_0000_0000_0000_0000_0000_0000_0000, "byterev_1");
    directed(2'd3, 128'h1, 128'h8000_0000_0000_0000_0000_0000_0000_0000, "bitrev_1");
    directed(2'd0, 128'hA5, 128'hA5, "pass_a5");

`ifdef SWIZZLE_PARITY_EN
    @(negedge clock);
    in_valid = 1'b1; in_mode = 2'd0; in_data = 128'h0301; out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("par_0301", out_par, 16'h0001);
    @(posedge clock); #1;
`endif

    // Back-pressure: three words offered while the consumer stalls.
    @(negedge clock);
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0; in_data = 128'h1111;
    @(negedge clock); in_data = 128'h2222;
    @(negedge clock); in_data = 128'h3333;
    check("bp_full_in_ready", in_ready, 0);
    check("bp_head", out_data, 128'h1111);
    @(negedge clock);
    check("bp_hold_in_ready", in_ready, 0);
    check("bp_hold_data", out_data, 128'h1111);
    out_ready = 1'b1;
    for (int k = 0; k < 8 && !in_ready; k++) @(negedge clock);
    check("bp_ready_timeout", in_ready, 1);
    check("bp_second", out_data, 128'h2222);
    @(negedge clock);
    in_valid = 1'b0;
    check("bp_third", out_data, 128'h3333);
    repeat (3) @(negedge clock);

    // Reset while FULL discards everything.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h4444;
    @(negedge clock); in_data = 128'h5555;
    @(negedge clock);
    in_valid = 1'b0;
    check("pre_rst_full", in_ready, 0);
    reset = 1'b1; in_valid = 1'b1;
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_xfer_cnt", xfer_cnt, 0);
    directed(2'd3, 128'h1, 128'h8000_0000_0000_0000_0000_0000_0000_0000, "post_rst");

    // 300-word stream at full rate from a zeroed counter.
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    out_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (!in_ready) stalls++;
      in_valid = 1'b1;
      in_mode  = 2'($urandom_range(0, 3));
      in_data  = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clock); in_valid = 1'b0;
    @(negedge clock);
    check("stream_stalls", stalls, 0);
    check("stream_cnt_wrap", xfer_cnt, 8'd44);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      reset     = ($urandom_range(0, 199) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      in_mode   = 2'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clock);
    check("final_drained", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_swizzle_pipe
`default_nettype wire
